// File: rtl/uart_tx_serializer.sv
// UART transmitter: 8N1 framing from a latched byte and a latched bit-period divider.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits, giving 8E1 framing.
module uart_tx_serializer #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cfg_en_i,
   input  logic [DIV_WIDTH-1:0] cfg_div_i,
   input  logic [7:0]           data_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic                 tx_o,
   output logic                 busy_o,
   output logic                 done_o
);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd4
   } state_t;
`endif

   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [7:0]           data_q, data_d;
   logic [2:0]           idx_q, idx_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic                 hs_s;
   logic                 bit_end_s;
   logic [2:0]           idx_next_s;

   assign ready_o    = (state_q == ST_IDLE) && cfg_en_i && !rst_i;
   assign hs_s       = ready_o && valid_i;
   assign bit_end_s  = (cnt_q == div_q);
   assign idx_next_s = idx_q + 3'd1;

   assign tx_o   = tx_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

   // Next-state, bit timing and registered line value for the following cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      data_d  = data_q;
      idx_d   = idx_q;
      tx_d    = tx_q;

      case (state_q)
         ST_IDLE: begin
            if (hs_s) begin
               data_d  = data_i;
               div_d   = cfg_div_i;
               cnt_d   = '0;
               idx_d   = 3'd0;
               state_d = ST_START;
               tx_d    = 1'b0;
            end else begin
               tx_d    = 1'b1;
            end
         end
         ST_START: begin
            if (bit_end_s) begin
               cnt_d   = '0;
               idx_d   = 3'd0;
               state_d = ST_DATA;
               tx_d    = data_q[0];
            end else begin
               cnt_d   = cnt_q + DIV_WIDTH'(1);
            end
         end
         ST_DATA: begin
            if (bit_end_s) begin
               cnt_d = '0;
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
                  tx_d    = even_parity(data_q);
`else
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  idx_d = idx_next_s;
                  tx_d  = data_q[idx_next_s];
               end
            end else begin
               cnt_d = cnt_q + DIV_WIDTH'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_end_s) begin
               cnt_d   = '0;
               state_d = ST_STOP;
               tx_d    = 1'b1;
            end else begin
               cnt_d   = cnt_q + DIV_WIDTH'(1);
            end
         end
`endif
         ST_STOP: begin
            if (bit_end_s) begin
               cnt_d   = '0;
               idx_d   = 3'd0;
               state_d = ST_IDLE;
               tx_d    = 1'b1;
            end else begin
               cnt_d   = cnt_q + DIV_WIDTH'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            idx_d   = 3'd0;
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // done is registered, so it is raised when the coming cycle is the last stop-bit cycle.
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_STOP) && (cnt_d == div_d);
   end

   // State and datapath registers; reset aborts any frame in progress.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         data_q  <= 8'd0;
         idx_q   <= 3'd0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter: DIV_WIDTH, 16, width of baud divider config and internal baud counter.
REQ-002 SHALL have port: clk_i  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: cfg_en_i  input  1  transmitter enable; gates acceptance of new bytes.
REQ-005 SHALL have port: cfg_div_i  input  DIV_WIDTH  bit period minus one, in clk_i cycles.
REQ-006 SHALL have port: data_i  input  8  byte to transmit.
REQ-007 SHALL have port: valid_i  input  1  data_i valid.
REQ-008 SHALL have port: ready_o  output  1  byte accepted when valid_i && ready_o at a clock edge.
REQ-009 SHALL have port: tx_o  output  1  serial line; idle high.
REQ-010 SHALL have port: busy_o  output  1  high while a frame is on the line.
REQ-011 SHALL have port: done_o  output  1  one-cycle pulse at end of stop bit.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL drive ready_o = (state==IDLE) && cfg_en_i && !rst_i, combinationally.
REQ-014 On handshake SHALL latch data_i and cfg_div_i into internal registers and enter START next cycle; later cfg_div_i changes do not affect the current frame.
REQ-015 Each bit SHALL last exactly latched_div+1 cycles, timed by a DIV_WIDTH baud counter counting 0..latched_div and restarting at each bit boundary.
REQ-016 START SHALL drive tx_o=0 for one bit period, then enter DATA.
REQ-017 DATA SHALL send 8 bits LSB first via a 3-bit index counter; after bit 7 go to PARITY if compiled in (REQ-026), else STOP.
REQ-018 STOP SHALL drive tx_o=1 for one bit period; in its last cycle done_o=1 and next state is IDLE.
REQ-019 tx_o SHALL be registered and equal 1 in IDLE; no combinational path from data_i to tx_o.
REQ-020 busy_o SHALL be 1 in every state other than IDLE.
REQ-021 Back-to-back: a byte offered on the IDLE cycle after STOP SHALL be accepted, giving exactly one idle-high cycle beyond the stop bit.
REQ-022 Deasserting cfg_en_i mid-frame SHALL NOT abort the frame; ready_o stays 0 afterwards until cfg_en_i returns.
REQ-023 cfg_div_i=0 SHALL give one clk_i cycle per bit; cfg_div_i = all-ones SHALL give 2^DIV_WIDTH cycles per bit without counter overflow.
REQ-024 valid_i without ready_o SHALL have no effect; data_i need not be held after handshake.

Reset
REQ-025 rst_i assertion, including mid-frame, SHALL immediately force state=IDLE, tx_o=1, busy_o=0, done_o=0, ready_o=0, all counters and latched registers to 0; the aborted frame is not resumed.

Configuration
REQ-026 With macro UART_TX_PARITY_EN defined, SHALL insert PARITY state after DATA, sending one bit equal to XOR of the 8 data bits (even parity), frame = 11 bit periods.
REQ-027 Without UART_TX_PARITY_EN, SHALL omit PARITY state and parity logic entirely, frame = 10 bit periods.

Verification
REQ-028 cfg_div_i=9, send 0x55 -> tx_o low 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, parity 0 (if enabled), stop high; done_o pulse 110 (parity) / 100 (no parity) cycles after handshake.
REQ-029 cfg_div_i=9, back-to-back 0x41 then 0x0A with valid_i held -> second start bit begins 1 idle cycle after first stop bit ends; line receiver decodes "A\n"; 0x41 parity bit 0, 0x0A parity bit 0.
REQ-030 cfg_div_i=0, send 0x80 -> 10 (or 11) consecutive-cycle bits 0,0000000,1,[1],1; done_o pulse on last stop cycle.
REQ-031 rst_i asserted during DATA bit 3 of 0xF0 -> tx_o=1, busy_o=0 same cycle (async); after release, ready_o=1 with cfg_en_i=1 and no residual bits emitted.
REQ-032 cfg_en_i dropped during START of 0x33 -> full frame emitted, done_o pulses, then ready_o stays 0 while valid_i=1 and tx_o stays 1.
REQ-033 cfg_div_i changed from 9 to 3 mid-frame -> current frame keeps 10-cycle bits; next frame uses 4-cycle bits.
